// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the keyboard lines, deframes
// 11-bit frames and tracks shift/break prefixes. Define PS2_SCAN_RX parity via PS2_PARITY_CHECK_EN.
module ps2_scan_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       letter_case,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]      FLT_LAST = 5'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic            filt_q, filt_d;
    logic [4:0]      fcnt_q, fcnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      data_sr_q, data_sr_d;
    logic            stop_q, stop_d;
    logic            lshift_q, lshift_d, rshift_q, rshift_d, brk_q, brk_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            letter_case_q, letter_case_d;
    logic            code_valid_q, code_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            bit_evt, par_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_q, par_d;
`endif

    always_comb begin
        state_d       = state_q;
        clk_s1_d      = ps2_clk;
        clk_s2_d      = clk_s1_q;
        dat_s1_d      = ps2_data;
        dat_s2_d      = dat_s1_q;
        filt_d        = filt_q;
        fcnt_d        = fcnt_q;
        bitcnt_d      = bitcnt_q;
        to_cnt_d      = to_cnt_q;
        data_sr_d     = data_sr_q;
        stop_d        = stop_q;
        lshift_d      = lshift_q;
        rshift_d      = rshift_q;
        brk_d         = brk_q;
        scan_code_d   = scan_code_q;
        letter_case_d = letter_case_q;
        code_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        bit_evt       = 1'b0;
        par_ok        = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        par_d         = par_q;
        par_ok        = ^{par_q, data_sr_q};
`endif

        // Level only flips after FILTER_LEN consecutive samples disagreeing with it
        if (clk_s2_q == filt_q) begin
            fcnt_d = 5'd0;
        end else if (fcnt_q == FLT_LAST) begin
            filt_d = clk_s2_q;
            fcnt_d = 5'd0;
        end else begin
            fcnt_d = fcnt_q + 5'd1;
        end
        bit_evt = filt_q & ~filt_d;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (bit_evt && !dat_s2_q) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd0;
                end
            end
            RECV: begin
                if (bit_evt) begin
                    to_cnt_d = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        data_sr_d = {dat_s2_q, data_sr_q[7:1]};
                    end
`ifdef PS2_PARITY_CHECK_EN
                    if (bitcnt_q == 4'd8) begin
                        par_d = dat_s2_q;
                    end
`endif
                    if (bitcnt_q == 4'd9) begin
                        stop_d  = dat_s2_q;
                        state_d = CHECK;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d    = '0;
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!stop_q || !par_ok) begin
                    frame_err_d = 1'b1;
                end else if (data_sr_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (data_sr_q == 8'hE0) begin
                    brk_d = brk_q;
                end else if (data_sr_q == 8'h12) begin
                    lshift_d = ~brk_q;
                    brk_d    = 1'b0;
                end else if (data_sr_q == 8'h59) begin
                    rshift_d = ~brk_q;
                    brk_d    = 1'b0;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                end else begin
                    scan_code_d   = data_sr_q;
                    letter_case_d = lshift_q | rshift_q;
                    code_valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_q        <= 1'b1;
            fcnt_q        <= 5'd0;
            bitcnt_q      <= 4'd0;
            to_cnt_q      <= '0;
            data_sr_q     <= 8'h00;
            stop_q        <= 1'b0;
            lshift_q      <= 1'b0;
            rshift_q      <= 1'b0;
            brk_q         <= 1'b0;
            scan_code_q   <= 8'h00;
            letter_case_q <= 1'b0;
            code_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            filt_q        <= filt_d;
            fcnt_q        <= fcnt_d;
            bitcnt_q      <= bitcnt_d;
            to_cnt_q      <= to_cnt_d;
            data_sr_q     <= data_sr_d;
            stop_q        <= stop_d;
            lshift_q      <= lshift_d;
            rshift_q      <= rshift_d;
            brk_q         <= brk_d;
            scan_code_q   <= scan_code_d;
            letter_case_q <= letter_case_d;
            code_valid_q  <= code_valid_d;
            frame_err_q   <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q         <= par_d;
`endif
        end
    end

    assign scan_code   = scan_code_q;
    assign letter_case = letter_case_q;
    assign code_valid  = code_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: drives PS/2 frames bit by bit and checks decoded outputs.
module tb_ps2_scan_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       letter_case;
    logic       code_valid;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    ps2_scan_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .letter_case(letter_case),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (code_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bits[0] is sent first
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_good, input logic stop);
        logic par;
        par = par_good ? ~^d : ^d;
        send_bits({stop, par, d, 1'b0}, 11);
        wait_cyc(40);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cyc(5);
        @(negedge clk);
        if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code: got %h expected 00", scan_code); end
        checks++;
        if (letter_case !== 1'b0) begin errors++; $display("FAIL reset_letter_case: got %b expected 0", letter_case); end
        checks++;
        if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_code_valid: got %b expected 0", code_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++;
        reset = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_basic;
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h16, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL basic_cv_count: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL basic_fe_count: got %0d expected 0", fe_cnt - fe0); end
        checks++;
        if (scan_code !== 8'h16) begin errors++; $display("FAIL basic_scan_code: got %h expected 16", scan_code); end
        checks++;
        if (letter_case !== 1'b0) begin errors++; $display("FAIL basic_letter_case: got %b expected 0", letter_case); end
        checks++;
    endtask

    task automatic test_stop_err;
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_fe_count: got %0d expected 1", fe_cnt - fe0); end
        checks++;
        if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL stop_cv_count: got %0d expected 0", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h16) begin errors++; $display("FAIL stop_scan_code_held: got %h expected 16", scan_code); end
        checks++;
    endtask

    task automatic test_shift;
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL shift_make_cv: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h22) begin errors++; $display("FAIL shift_make_code: got %h expected 22", scan_code); end
        checks++;
        if (letter_case !== 1'b1) begin errors++; $display("FAIL shift_make_case: got %b expected 1", letter_case); end
        checks++;
        cv0 = cv_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL shift_break_cv: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h22) begin errors++; $display("FAIL shift_break_code: got %h expected 22", scan_code); end
        checks++;
        if (letter_case !== 1'b0) begin errors++; $display("FAIL shift_break_case: got %b expected 0", letter_case); end
        checks++;
        if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL shift_fe_count: got %0d expected 0", fe_cnt - fe0); end
        checks++;
    endtask

    task automatic test_parity;
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h1E, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL parity_fe_count: got %0d expected 1", fe_cnt - fe0); end
        checks++;
        if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL parity_cv_count: got %0d expected 0", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h22) begin errors++; $display("FAIL parity_code_held: got %h expected 22", scan_code); end
        checks++;
`else
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL parity_cv_count: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL parity_fe_count: got %0d expected 0", fe_cnt - fe0); end
        checks++;
        if (scan_code !== 8'h1E) begin errors++; $display("FAIL parity_scan_code: got %h expected 1e", scan_code); end
        checks++;
`endif
    endtask

    task automatic test_e0_break;
        int cv0;
        cv0 = cv_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h74, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL e0_break_cv: got %0d expected 0", cv_cnt - cv0); end
        checks++;
        send_frame(8'h74, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL e0_make_cv: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h74) begin errors++; $display("FAIL e0_make_code: got %h expected 74", scan_code); end
        checks++;
    endtask

    task automatic test_glitch;
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        wait_cyc(30);
        ps2_data = 1'b1;
        wait_cyc(30);
        if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_fe_count: got %0d expected 0", fe_cnt - fe0); end
        checks++;
        send_frame(8'h26, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL glitch_cv_count: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h26) begin errors++; $display("FAIL glitch_scan_code: got %h expected 26", scan_code); end
        checks++;
    endtask

    task automatic test_timeout;
        int cv0, fe0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_bits({2'b11, 8'h44, 1'b0}, 5);
        wait_cyc(TIMEOUT_CYC + 2);
        if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_fe_count: got %0d expected 1", fe_cnt - fe0); end
        checks++;
        if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL timeout_cv_count: got %0d expected 0", cv_cnt - cv0); end
        checks++;
        send_frame(8'h44, 1'b1, 1'b1);
        if (scan_code !== 8'h44) begin errors++; $display("FAIL timeout_next_code: got %h expected 44", scan_code); end
        checks++;
        if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_next_fe: got %0d expected 1", fe_cnt - fe0); end
        checks++;
    endtask

    task automatic test_reset_midframe;
        int cv0;
        cv0 = cv_cnt;
        send_bits({2'b10, 8'h3D, 1'b0}, 4);
        reset = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        if (scan_code !== 8'h00) begin errors++; $display("FAIL midrst_scan_code: got %h expected 00", scan_code); end
        checks++;
        if (letter_case !== 1'b0) begin errors++; $display("FAIL midrst_letter_case: got %b expected 0", letter_case); end
        checks++;
        if (code_valid !== 1'b0) begin errors++; $display("FAIL midrst_code_valid: got %b expected 0", code_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
        checks++;
        reset = 1'b0;
        wait_cyc(20);
        if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL midrst_cv_count: got %0d expected 0", cv_cnt - cv0); end
        checks++;
        send_frame(8'h3D, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL midrst_next_cv: got %0d expected 1", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h3D) begin errors++; $display("FAIL midrst_next_code: got %h expected 3d", scan_code); end
        checks++;
    endtask

    task automatic test_back_to_back;
        int cv0;
        cv0 = cv_cnt;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b1, 1'b1);
        if (cv_cnt - cv0 !== 3) begin errors++; $display("FAIL typematic_cv_count: got %0d expected 3", cv_cnt - cv0); end
        checks++;
        if (scan_code !== 8'h1C) begin errors++; $display("FAIL typematic_code: got %h expected 1c", scan_code); end
        checks++;
        if (letter_case !== 1'b0) begin errors++; $display("FAIL typematic_case: got %b expected 0", letter_case); end
        checks++;
    endtask

    task automatic test_exclusive;
        if (both_cnt !== 0) begin errors++; $display("FAIL cv_fe_overlap: got %0d cycles expected 0", both_cnt); end
        checks++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stop_err;
        test_shift;
        test_parity;
        test_e0_break;
        test_glitch;
        test_timeout;
        test_reset_midframe;
        test_back_to_back;
        test_exclusive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal ps2_clk samples required to change the filtered clock level (range 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: clk cycles without a filtered falling edge before an in-progress frame is aborted.
REQ-003 SHALL have port clk, input, 1: system clock; the only clock in the block.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1: raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 SHALL have port scan_code, output, 8: last accepted make code, held until the next code_valid.
REQ-008 SHALL have port letter_case, output, 1: shift state captured with scan_code (1 = either shift held).
REQ-009 SHALL have port code_valid, output, 1: single-cycle pulse when scan_code/letter_case update.
REQ-010 SHALL have port frame_err, output, 1: single-cycle pulse on a rejected or aborted frame.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two-flop synchronizers before any use.
REQ-012 SHALL drive filtered clock low only after FILTER_LEN consecutive synchronized 0 samples and high only after FILTER_LEN consecutive 1 samples; otherwise it holds its level.
REQ-013 SHALL treat a filtered 1->0 transition as a bit event and sample synchronized ps2_data in that same cycle.
REQ-014 SHALL implement FSM states IDLE, RECV, CHECK; reset state IDLE.
REQ-015 IDLE: bit event with data 0 -> RECV, bit counter cleared; bit event with data 1 ignored, no frame_err.
REQ-016 RECV: shift in 10 bits LSB first (8 data, parity, stop); 10th bit event -> CHECK.
REQ-017 RECV: timeout counter clears on each bit event; reaching TIMEOUT_CYC -> IDLE plus one frame_err pulse, partial frame discarded.
REQ-018 CHECK lasts exactly one cycle, then -> IDLE; stop bit 0 -> frame_err pulse, byte discarded.
REQ-019 Accepted byte 0xF0: set break_pending; no code_valid.
REQ-020 Accepted byte 0xE0: discarded, no code_valid, break_pending unchanged.
REQ-021 Accepted byte 0x12 or 0x59: updates left/right shift flag (set on make, clear if break_pending), clears break_pending; no code_valid.
REQ-022 Any other accepted byte with break_pending set: clear break_pending; no code_valid.
REQ-023 Any other accepted byte with break_pending clear: load scan_code = byte and letter_case = left_shift OR right_shift, pulse code_valid.
REQ-024 code_valid and frame_err SHALL assert on the cycle immediately after the FSM is in CHECK, high for exactly one cycle; never both in the same cycle.
REQ-025 Repeated make codes (typematic) SHALL each produce a code_valid.

Reset
REQ-026 reset SHALL asynchronously force: state IDLE, scan_code 0x00, letter_case 0, code_valid 0, frame_err 0, shift and break_pending flags 0, counters 0, filter and synchronizers to idle-high (1).
REQ-027 Reset mid-frame SHALL discard the partial frame; the first complete frame after release is received correctly.

Configuration
REQ-028 With PS2_PARITY_CHECK_EN defined: CHECK requires odd parity over 8 data bits plus parity bit; mismatch -> frame_err pulse, byte discarded.
REQ-029 Without PS2_PARITY_CHECK_EN: parity bit ignored; only stop bit checked.

Verification
REQ-030 Frame 0x16, parity 0, stop 1 -> one code_valid, scan_code 0x16, letter_case 0, no frame_err.
REQ-031 Frames 0x12, 0x22 -> code_valid once, scan_code 0x22, letter_case 1; then 0xF0,0x22,0xF0,0x12,0x22 -> exactly one further code_valid, scan_code 0x22, letter_case 0.
REQ-032 Frame 0x1E with parity 0 (bad) -> macro defined: frame_err pulse, no code_valid; macro undefined: code_valid, scan_code 0x1E.
REQ-033 ps2_clk low glitch of FILTER_LEN-1 clk cycles while IDLE, data 0 -> FSM stays IDLE; following frame 0x26 decoded as 0x26.
REQ-034 5 bits sent then ps2_clk held high TIMEOUT_CYC+2 cycles -> one frame_err, IDLE; next frame 0x44 -> scan_code 0x44.
REQ-035 reset pulsed after 4 bits of frame 0x3D -> all outputs 0 during reset, no code_valid; next full frame 0x3D -> scan_code 0x3D.
